// File: rtl/pico_io_bridge.sv
// Port-bus bridge for the PicoBlaze/PacoBlaze core: registered input mux, strobed output
// registers, edge-triggered interrupt controller and start/done handshake. Optional macro: PICO_IO_READBACK_EN.
module pico_io_bridge #(
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned NUM_OUT  = 4,
    parameter int unsigned NUM_IRQ  = 4,
    parameter logic [7:0]  OUT_BASE = 8'h80
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             port_id,
    input  logic [7:0]             out_port,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    output logic [7:0]             in_port,
    output logic                   interrupt,
    input  logic                   interrupt_ack,
    input  logic [8*NUM_IN-1:0]    in_data,
    output logic [8*NUM_OUT-1:0]   out_data,
    output logic [NUM_OUT-1:0]     out_wr,
    input  logic [NUM_IRQ-1:0]     irq_src,
    input  logic                   start_req,
    output logic                   done
);

    localparam logic [7:0] ID_PENDING = 8'h40;
    localparam logic [7:0] ID_MASK    = 8'h41;
    localparam logic [7:0] ID_STATUS  = 8'h42;
    localparam logic [7:0] ID_CTRL    = 8'h43;

    logic [7:0]           in_port_q, in_port_d;
    logic                 interrupt_q, interrupt_d;
    logic [8*NUM_OUT-1:0] out_data_q, out_data_d;
    logic [NUM_OUT-1:0]   out_wr_q, out_wr_d;
    logic                 done_q, done_d;
    logic                 start_flag_q, start_flag_d;
    logic                 start_prev_q, start_prev_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0]   exposed_prev_q, exposed_prev_d;

    logic                 fixed_hit_s;
    logic                 pend_wr_s;
    logic                 mask_wr_s;
    logic                 ctrl_wr_s;
    logic                 start_rise_s;
    logic [NUM_IRQ-1:0]   irq_rise_s;
    logic [NUM_IRQ-1:0]   exposed_s;
    logic                 irq_event_s;
    logic [7:0]           pending_rd_s;
    logic [7:0]           mask_rd_s;
    logic                 unused_s;

    // read_strobe has no side effects in this bridge
    assign unused_s = read_strobe;

    // Address decode and edge detection shared by the update logic below
    always_comb begin
        fixed_hit_s  = (port_id >= ID_PENDING) && (port_id <= ID_CTRL);
        pend_wr_s    = write_strobe && (port_id == ID_PENDING);
        mask_wr_s    = write_strobe && (port_id == ID_MASK);
        ctrl_wr_s    = write_strobe && (port_id == ID_CTRL);
        start_rise_s = start_req && !start_prev_q;
        irq_rise_s   = irq_src & ~irq_prev_q;
        exposed_s    = pending_q & mask_q;
        // An event is a bit of pending&mask that was not exposed last cycle
        irq_event_s  = |(exposed_s & ~exposed_prev_q);
        pending_rd_s = 8'h00;
        pending_rd_s[NUM_IRQ-1:0] = pending_q;
        mask_rd_s    = 8'h00;
        mask_rd_s[NUM_IRQ-1:0] = mask_q;
    end

    // Read mux: fixed registers first, then input channels, then optional readback
    always_comb begin
        in_port_d = 8'h00;
        if (port_id == ID_PENDING) begin
            in_port_d = pending_rd_s;
        end else if (port_id == ID_MASK) begin
            in_port_d = mask_rd_s;
        end else if (port_id == ID_STATUS) begin
            in_port_d = {6'b00_0000, done_q, start_flag_q};
        end else if (fixed_hit_s) begin
            in_port_d = 8'h00;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (port_id == 8'(k)) begin
                    in_port_d = in_data[8*k +: 8];
                end else begin
                    in_port_d = in_port_d;
                end
            end
`ifdef PICO_IO_READBACK_EN
            for (int k = 0; k < NUM_OUT; k++) begin
                if (port_id == OUT_BASE + 8'(k)) begin
                    in_port_d = out_data_q[8*k +: 8];
                end else begin
                    in_port_d = in_port_d;
                end
            end
`endif
        end
    end

    // Output registers and their one-cycle write pulses
    always_comb begin
        out_data_d = out_data_q;
        out_wr_d   = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (write_strobe && !fixed_hit_s && (port_id == OUT_BASE + 8'(k))) begin
                out_data_d[8*k +: 8] = out_port;
                out_wr_d[k]          = 1'b1;
            end else begin
                out_wr_d[k]          = 1'b0;
            end
        end
    end

    // Interrupt controller: new edges win over W1C; a new event wins over ack
    always_comb begin
        irq_prev_d     = irq_src;
        exposed_prev_d = exposed_s;
        pending_d      = (pend_wr_s ? (pending_q & ~out_port[NUM_IRQ-1:0]) : pending_q) | irq_rise_s;
        mask_d         = mask_wr_s ? out_port[NUM_IRQ-1:0] : mask_q;
        if (irq_event_s) begin
            interrupt_d = 1'b1;
        end else if (interrupt_ack) begin
            interrupt_d = 1'b0;
        end else begin
            interrupt_d = interrupt_q;
        end
    end

    // Start/done handshake: a control write overrides the automatic clear of done
    always_comb begin
        start_prev_d = start_req;
        if (ctrl_wr_s && out_port[1]) begin
            done_d = 1'b0;
        end else if (ctrl_wr_s && out_port[0]) begin
            done_d = 1'b1;
        end else if (start_rise_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        if (start_rise_s) begin
            start_flag_d = 1'b1;
        end else if (ctrl_wr_s && out_port[2]) begin
            start_flag_d = 1'b0;
        end else begin
            start_flag_d = start_flag_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_port_q      <= 8'h00;
            interrupt_q    <= 1'b0;
            out_data_q     <= '0;
            out_wr_q       <= '0;
            done_q         <= 1'b0;
            start_flag_q   <= 1'b0;
            start_prev_q   <= 1'b0;
            pending_q      <= '0;
            mask_q         <= '0;
            irq_prev_q     <= '0;
            exposed_prev_q <= '0;
        end else begin
            in_port_q      <= in_port_d;
            interrupt_q    <= interrupt_d;
            out_data_q     <= out_data_d;
            out_wr_q       <= out_wr_d;
            done_q         <= done_d;
            start_flag_q   <= start_flag_d;
            start_prev_q   <= start_prev_d;
            pending_q      <= pending_d;
            mask_q         <= mask_d;
            irq_prev_q     <= irq_prev_d;
            exposed_prev_q <= exposed_prev_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = interrupt_q;
    assign out_data  = out_data_q;
    assign out_wr    = out_wr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pico_io_bridge.sv
// Directed self-checking bench for pico_io_bridge with default parameters.
module tb_pico_io_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack;
    logic [31:0] in_data;
    logic [31:0] out_data;
    logic [3:0]  out_wr;
    logic [3:0]  irq_src;
    logic        start_req;
    logic        done;

    int cmp_cnt = 0;
    int err_cnt = 0;

    pico_io_bridge dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .in_data       (in_data),
        .out_data      (out_data),
        .out_wr        (out_wr),
        .irq_src       (irq_src),
        .start_req     (start_req),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        port_id      = id;
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id);
        port_id = id;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0;
        read_strobe = 1'b0; interrupt_ack = 1'b0; in_data = 32'h0; irq_src = 4'h0; start_req = 1'b0;
        tick(); tick();
        check_val("rst_in_port", 32'(in_port), 32'h00);
        check_val("rst_irq", 32'(interrupt), 32'h0);
        check_val("rst_out_data", out_data, 32'h0);
        check_val("rst_out_wr", 32'(out_wr), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        rd(8'h40); check_val("rst_rd40", 32'(in_port), 32'h00);
        rd(8'h41); check_val("rst_rd41", 32'(in_port), 32'h00);
        rd(8'h42); check_val("rst_rd42", 32'(in_port), 32'h00);
        rd(8'h10); check_val("rst_rd10", 32'(in_port), 32'h00);

        // read mux latency
        in_data = 32'h00A5_0000;
        port_id = 8'h02;
        check_val("mux_not_early", 32'(in_port), 32'h00);
        tick(); check_val("mux_ch2", 32'(in_port), 32'hA5);
        rd(8'hFF); check_val("mux_unmapped", 32'(in_port), 32'h00);

        // readback
        wr(8'h81, 8'h3C);
        check_val("wr81_pulse", 32'(out_wr), 32'h2);
        rd(8'h81);
`ifdef PICO_IO_READBACK_EN
        check_val("readback81", 32'(in_port), 32'h3C);
`else
        check_val("readback81", 32'(in_port), 32'h00);
`endif

        // output write
        wr(8'h83, 8'h5A);
        check_val("wr83_data", out_data, 32'h5A00_3C00);
        check_val("wr83_pulse", 32'(out_wr), 32'h8);
        tick();
        check_val("wr83_pulse_end", 32'(out_wr), 32'h0);
        check_val("wr83_hold", out_data, 32'h5A00_3C00);

        // interrupt flow
        wr(8'h41, 8'h05);
        rd(8'h41); check_val("mask_rd", 32'(in_port), 32'h05);
        irq_src = 4'b0100; tick(); irq_src = 4'b0000;
        check_val("irq_lat1", 32'(interrupt), 32'h0);
        port_id = 8'h40; tick();
        check_val("irq_lat2", 32'(interrupt), 32'h1);
        check_val("pending_04", 32'(in_port), 32'h04);
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        check_val("ack_drop", 32'(interrupt), 32'h0);
        tick(); tick();
        check_val("ack_stay0", 32'(interrupt), 32'h0);
        wr(8'h40, 8'h04);
        rd(8'h40); check_val("w1c_pending", 32'(in_port), 32'h00);

        // new event coincides with ack: interrupt must stay high
        irq_src = 4'b0100; tick(); irq_src = 4'b0000; tick();
        check_val("irq_rearm", 32'(interrupt), 32'h1);
        irq_src = 4'b0001; tick(); irq_src = 4'b0000;
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        check_val("evt_ack_same", 32'(interrupt), 32'h1);
        tick();
        check_val("evt_ack_hold", 32'(interrupt), 32'h1);
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        check_val("ack2_drop", 32'(interrupt), 32'h0);
        wr(8'h40, 8'h05);

        // masked source exposed later by a mask write
        irq_src = 4'b0010; tick(); irq_src = 4'b0000; tick(); tick();
        check_val("masked_quiet", 32'(interrupt), 32'h0);
        rd(8'h40); check_val("masked_pending", 32'(in_port), 32'h02);
        wr(8'h41, 8'h02);
        tick();
        check_val("mask_expose", 32'(interrupt), 32'h1);

        // start/done handshake
        start_req = 1'b1; tick();
        rd(8'h42); check_val("start_flag", 32'(in_port), 32'h01);
        wr(8'h43, 8'h05);
        check_val("done_set", 32'(done), 32'h1);
        rd(8'h42); check_val("status_02", 32'(in_port), 32'h02);
        start_req = 1'b0; tick(); start_req = 1'b1; tick();
        check_val("done_autoclr", 32'(done), 32'h0);
        rd(8'h42); check_val("status_01", 32'(in_port), 32'h01);

        // reset during a write discards it
        port_id = 8'h80; out_port = 8'hFF; write_strobe = 1'b1; reset_n = 1'b0;
        tick();
        write_strobe = 1'b0;
        check_val("midrst_out_data", out_data, 32'h0);
        check_val("midrst_out_wr", 32'(out_wr), 32'h0);
        check_val("midrst_in_port", 32'(in_port), 32'h00);
        check_val("midrst_irq", 32'(interrupt), 32'h0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pico_io_bridge.md
# pico_io_bridge

- Parametrised port-bus bridge between the PicoBlaze/PacoBlaze soft core and fabric logic.
- Provides:
  - NUM_IN registered input channels behind a pipelined read mux.
  - NUM_OUT write-strobed output registers.
  - A NUM_IRQ-source interrupt controller with pending/mask registers and an ack handshake.
  - A start/done handshake pair for sequencing the core against hardware.
- Sits directly on the core's port_id/in_port/out_port/strobe bus, in place of hand-written per-design port logic.

## Interface
Parameters:
- NUM_IN, 4, input channels (1..16), read at port_id 8'h00+k
- NUM_OUT, 4, output registers (1..16), written at OUT_BASE+k
- NUM_IRQ, 4, interrupt sources (1..8)
- OUT_BASE, 8'h80, base port_id of output registers

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- port_id  in  8  core port address
- out_port  in  8  core write data
- write_strobe  in  1  core write qualifier
- read_strobe  in  1  core read qualifier (unused for side effects)
- in_port  out  8  read data to core
- interrupt  out  1  interrupt request to core
- interrupt_ack  in  1  core interrupt acknowledge
- in_data  in  8*NUM_IN  fabric input channels, channel k at [8k+7:8k]
- out_data  out  8*NUM_OUT  output registers, channel k at [8k+7:8k]
- out_wr  out  NUM_OUT  one-cycle pulse per channel written
- irq_src  in  NUM_IRQ  interrupt sources, rising-edge sensitive
- start_req  in  1  fabric start request (level)
- done  out  1  core-driven completion flag

## Operation
- Reset (reset_n=0 at clk edge) clears in_port, interrupt, out_data, out_wr, done, pending, mask, start_flag, and the edge-detect history.
- Port map, reads:
  - 8'h00+k (k<NUM_IN): in_data channel k
  - 8'h40: pending
  - 8'h41: mask
  - 8'h42: {6'b0, done, start_flag}
  - all unmapped ids: 8'h00, never X
- Port map, writes when write_strobe=1:
  - OUT_BASE+k (k<NUM_OUT): out_data[k] <= out_port; out_wr[k]=1 for one cycle.
  - 8'h40: write-1-to-clear pending bits.
  - 8'h41: mask <= out_port[NUM_IRQ-1:0].
  - 8'h43: control.
    - bit0=1 sets done.
    - bit1=1 clears done.
    - bit2=1 clears start_flag.
    - bit0 and bit1 both 1: done cleared.
  - Writes to any other id are ignored.
- Pending:
  - pending[i] sets when irq_src[i] is high and was low the previous cycle.
  - Same-cycle set and W1C of the same bit: set wins.
- Interrupt request:
  - irq_event = some bit of (pending&mask) goes 0->1 this cycle, from a new edge or from a mask write exposing a pending bit.
  - interrupt <= 1 on irq_event; otherwise <= 0 on interrupt_ack; otherwise holds.
  - irq_event and interrupt_ack in the same cycle: interrupt stays 1, so the event is not lost.
  - Already-pending, already-signalled bits do not re-raise interrupt after ack; the ISR must W1C them.
- Start/done handshake:
  - start_flag sets on a start_req rising edge.
  - done clears automatically on a start_req rising edge unless a control write sets done in the same cycle; the write wins.

## Timing
- in_port is registered: valid one cycle after port_id is presented. There is no read side effect.
- out_data[k] and out_wr[k] update on the clk edge where write_strobe is sampled high. out_wr is high for exactly that one following cycle.
- irq_src edge to pending: 1 cycle. irq_src edge to interrupt: 2 cycles (edge register, then pending/event).
- interrupt drops 1 cycle after interrupt_ack is sampled.
- reset_n low mid-transaction: the next edge forces all reset values and discards in-flight writes. in_port is 8'h00 the cycle after reset.
- OUT_BASE ranges overlapping the fixed registers (8'h40..8'h43): the fixed registers take priority.

## Configuration
- Macro: PICO_IO_READBACK_EN.
- Defined: reads of OUT_BASE+k return out_data[k], letting firmware do read-modify-write.
- Undefined: those reads return 8'h00 and no readback mux is built.

## Test plan
- Reset and default reads:
  - Stimulus: hold reset_n low 2 cycles, release, read ids 8'h40, 8'h41, 8'h42 and 8'h10.
  - Required: every output is 0, and each read returns 8'h00.
- Read mux:
  - Stimulus: in_data channel 2 = 8'hA5, port_id = 8'h02.
  - Required: in_port = 8'hA5 exactly one cycle later. With PICO_IO_READBACK_EN, after a write of 8'h3C to 8'h81, a read of 8'h81 returns 8'h3C; without it, 8'h00.
- Output write:
  - Stimulus: write 8'h5A to 8'h83.
  - Required: out_data channel 3 = 8'h5A and out_wr = 4'b1000 for one cycle; all other channels unchanged.
- Interrupt flow:
  - Stimulus: mask = 8'h05, pulse irq_src[2].
  - Required: pending = 8'h04 and interrupt=1 two cycles after the edge.
  - Stimulus: interrupt_ack.
  - Required: interrupt=0 next cycle and stays 0. W1C 8'h04 to 8'h40 clears pending.
- Interrupt corner cases:
  - Stimulus: irq_src[0] edge in the same cycle as interrupt_ack.
  - Required: interrupt stays 1.
  - Stimulus: masked-off irq_src[1] edge, then mask write 8'h02.
  - Required: interrupt=1.
- Start/done handshake:
  - Stimulus: start_req rising edge.
  - Required: read of 8'h42 returns 8'h01.
  - Stimulus: control write 8'h05.
  - Required: read returns 8'h02.
  - Stimulus: next start_req edge.
  - Required: done=0, start_flag=1.
